// File: rtl/mmio_timer_pkg.sv
// Shared constants for the mmio_timer peripheral: register offsets inside
// the 32-byte window, CTRL/STATUS bit positions, the response FSM state
// encoding, and the read-data pattern returned on a decode miss when the
// MMIO_TIMER_ERR_EN build option is on.
package mmio_timer_pkg;

    localparam logic [4:0] OFF_CTRL     = 5'h00;
    localparam logic [4:0] OFF_PRESCALE = 5'h04;
    localparam logic [4:0] OFF_COUNT    = 5'h08;
    localparam logic [4:0] OFF_COMPARE  = 5'h0C;
    localparam logic [4:0] OFF_STATUS   = 5'h10;

    localparam int CTRL_ENABLE_BIT      = 0;
    localparam int CTRL_AUTO_RELOAD_BIT = 1;
    localparam int CTRL_IRQ_EN_BIT      = 2;
    localparam int STATUS_MATCH_BIT     = 0;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Prescaler for mmio_timer. Produces one tick every (prescale+1) enabled
// cycles, or follows the step pulse in debug mode.
// Ports:
//   clk, rst    system clock, synchronous active-high reset
//   enable      timer enable (CTRL.enable)
//   debug_mode  1 = tick follows step, prescaler holds
//   step        single-cycle step pulse
//   prescale    current PRESCALE register value
//   clear       restart the prescale period (PRESCALE write)
//   tick        counter advance strobe
//
// Implemented as a down-counter with a terminal-count compare. load_q marks
// "period restarted": the remaining count is then taken from the live
// prescale value, so a PRESCALE write takes effect in the very next cycle.
module mmio_timer_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  debug_mode,
    input  logic                  step,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clear,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] remain_q, remain_d;
    logic                  load_q, load_d;
    logic [PRESCALE_W-1:0] remain_eff;

    always_comb begin
        remain_eff = load_q ? prescale : remain_q;
        remain_d   = remain_q;
        load_d     = load_q;
        tick       = 1'b0;
        if (enable) begin
            if (debug_mode) begin
                tick = step;
            end else if (remain_eff == '0) begin
                tick   = 1'b1;
                load_d = 1'b1;
            end else begin
                remain_d = remain_eff - PRESCALE_W'(1);
                load_d   = 1'b0;
            end
        end
        if (clear || !enable) begin
            load_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            remain_q <= '0;
            load_q   <= 1'b1;
        end else begin
            remain_q <= remain_d;
            load_q   <= load_d;
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped timer responder. Decodes a 32-byte register window at
// BASE_ADDR, answers every request through a one-entry response stage, and
// runs a prescaled 32-bit counter with compare match and interrupt.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready/req_we/
//   req_addr/req_wdata               request channel
//   rsp_valid/rsp_ready/rsp_rdata/
//   rsp_err                          response channel
//   debug_mode, step                 counter follows step when debug_mode=1
//   irq                              STATUS.match & CTRL.irq_en, registered
// Build option: MMIO_TIMER_ERR_EN -- when defined, a decode miss returns
// rsp_err=1 with rsp_rdata=32'hDEAD_BEEF; otherwise misses read 0 and
// rsp_err is tied low. Writes that miss are always dropped.
//
// Response FSM:
//   state | meaning
//   IDLE  | ready for a request; register access happens on acceptance
//   RESP  | response held until rsp_ready
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0100,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        debug_mode,
    input  logic        step,
    output logic        irq
);

    rsp_state_e            state_q, state_d;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [31:0]           count_q, count_d;
    logic [31:0]           compare_q, compare_d;
    logic                  match_q, match_d;
    logic                  irq_q, irq_d;
    logic [31:0]           rdata_q, rdata_d;
`ifdef MMIO_TIMER_ERR_EN
    logic                  err_q, err_d;
`endif

    logic        tick;
    logic        presc_clear;
    logic        hit;
    logic        accept;
    logic        wr;
    logic        match_set;
    logic [4:0]  offset;
    logic [31:0] rd_val;

    assign offset = req_addr[4:0];
    assign hit    = (req_addr[31:5] == BASE_ADDR[31:5]) &&
                    (offset <= OFF_STATUS) && (req_addr[1:0] == 2'b00);
    assign accept = (state_q == ST_IDLE) && req_valid;
    assign wr     = accept && req_we && hit;

    mmio_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable     (ctrl_q[CTRL_ENABLE_BIT]),
        .debug_mode (debug_mode),
        .step       (step),
        .prescale   (prescale_q),
        .clear      (presc_clear),
        .tick       (tick)
    );

    // Reads see register values from before this cycle's update.
    always_comb begin
        rd_val = '0;
        case (offset)
            OFF_CTRL:     rd_val = {29'b0, ctrl_q};
            OFF_PRESCALE: rd_val = 32'(prescale_q);
            OFF_COUNT:    rd_val = count_q;
            OFF_COMPARE:  rd_val = compare_q;
            OFF_STATUS:   rd_val = {31'b0, match_q};
            default:      rd_val = '0;
        endcase
    end

    always_comb begin
        ctrl_d      = ctrl_q;
        prescale_d  = prescale_q;
        count_d     = count_q;
        compare_d   = compare_q;
        match_d     = match_q;
        presc_clear = 1'b0;
        match_set   = 1'b0;

        if (tick) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = ctrl_q[CTRL_AUTO_RELOAD_BIT] ? 32'd0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        // Software writes override the tick update of the same register.
        if (wr) begin
            case (offset)
                OFF_CTRL:     ctrl_d = req_wdata[2:0];
                OFF_PRESCALE: begin
                    prescale_d  = req_wdata[PRESCALE_W-1:0];
                    presc_clear = 1'b1;
                end
                OFF_COUNT:    count_d   = req_wdata;
                OFF_COMPARE:  compare_d = req_wdata;
                OFF_STATUS:   if (req_wdata[STATUS_MATCH_BIT]) match_d = 1'b0;
                default:      ;
            endcase
        end

        // A fresh match beats a simultaneous W1C.
        if (match_set) begin
            match_d = 1'b1;
        end
        irq_d = match_d & ctrl_d[CTRL_IRQ_EN_BIT];
    end

    always_comb begin
        state_d   = state_q;
        rdata_d   = rdata_q;
        req_ready = (state_q == ST_IDLE);
        rsp_valid = (state_q == ST_RESP);
`ifdef MMIO_TIMER_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_RESP;
                    if (hit) begin
                        rdata_d = req_we ? 32'd0 : rd_val;
`ifdef MMIO_TIMER_ERR_EN
                        err_d   = 1'b0;
`endif
                    end else begin
`ifdef MMIO_TIMER_ERR_EN
                        rdata_d = ERR_RDATA;
                        err_d   = 1'b1;
`else
                        rdata_d = 32'd0;
`endif
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            prescale_q <= '0;
            count_q    <= '0;
            compare_q  <= '0;
            match_q    <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef MMIO_TIMER_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            match_q    <= match_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
`ifdef MMIO_TIMER_ERR_EN
            err_q      <= err_d;
`endif
        end
    end

    assign rsp_rdata = rdata_q;
    assign irq       = irq_q;
`ifdef MMIO_TIMER_ERR_EN
    assign rsp_err   = err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
`timescale 1ns/1ps
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hF000_0100;
    localparam int          PW   = 16;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_PRE  = BASE + 32'h04;
    localparam logic [31:0] A_CNT  = BASE + 32'h08;
    localparam logic [31:0] A_CMP  = BASE + 32'h0C;
    localparam logic [31:0] A_STAT = BASE + 32'h10;
`ifdef MMIO_TIMER_ERR_EN
    localparam logic [31:0] MISS_RD  = 32'hDEAD_BEEF;
    localparam logic        MISS_ERR = 1'b1;
`else
    localparam logic [31:0] MISS_RD  = 32'h0;
    localparam logic        MISS_ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        debug_mode, step, irq;

    mmio_timer #(.BASE_ADDR(BASE), .PRESCALE_W(PW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .debug_mode(debug_mode), .step(step), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: registers as plain values, prescaler as an up-counter.
    bit          m_resp, m_err, m_irq, m_match;
    logic [31:0] m_rdata, m_count, m_compare;
    logic [2:0]  m_ctrl;
    int unsigned m_presc, m_pcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        bit          hit, acc, tk, set, n_match;
        int unsigned idx, n_pcnt, n_presc;
        logic [31:0] rv, n_count, n_compare;
        logic [2:0]  n_ctrl;
        if (rst) begin
            m_resp = 0; m_err = 0; m_irq = 0; m_match = 0; m_rdata = 0;
            m_count = 0; m_compare = 0; m_ctrl = 0; m_presc = 0; m_pcnt = 0;
        end else begin
            hit = (req_addr >= BASE) && (req_addr <= BASE + 32'h10) && (req_addr % 4 == 0);
            idx = (req_addr - BASE) / 4;
            acc = !m_resp && req_valid;
            rv = 0;
            if (hit) begin
                case (idx)
                    0: rv = 32'(m_ctrl);
                    1: rv = m_presc;
                    2: rv = m_count;
                    3: rv = m_compare;
                    default: rv = 32'(m_match);
                endcase
            end
            n_pcnt = m_pcnt; tk = 0;
            if (!m_ctrl[0]) n_pcnt = 0;
            else if (debug_mode) tk = step;
            else begin
                tk = (m_pcnt == m_presc);
                n_pcnt = tk ? 0 : m_pcnt + 1;
            end
            n_count = m_count; n_compare = m_compare; n_ctrl = m_ctrl;
            n_presc = m_presc; n_match = m_match; set = 0;
            if (tk) begin
                if (m_count == m_compare) begin
                    set = 1;
                    n_count = m_ctrl[1] ? 32'd0 : m_count + 1;
                end else n_count = m_count + 1;
            end
            if (acc && req_we && hit) begin
                case (idx)
                    0: n_ctrl = req_wdata[2:0];
                    1: begin n_presc = req_wdata & ((1 << PW) - 1); n_pcnt = 0; end
                    2: n_count = req_wdata;
                    3: n_compare = req_wdata;
                    default: if (req_wdata[0]) n_match = 0;
                endcase
            end
            if (set) n_match = 1;
            if (acc) begin
                m_resp = 1;
                if (hit) begin m_rdata = req_we ? 32'd0 : rv; m_err = 0; end
                else begin m_rdata = MISS_RD; m_err = MISS_ERR; end
            end else if (m_resp && rsp_ready) m_resp = 0;
            m_ctrl = n_ctrl; m_presc = n_presc; m_pcnt = n_pcnt; m_count = n_count;
            m_compare = n_compare; m_match = n_match;
            m_irq = n_match & n_ctrl[2];
        end
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("req_ready", req_ready, 32'(!m_resp));
        chk("rsp_valid", rsp_valid, 32'(m_resp));
        chk("irq", irq, 32'(m_irq));
        if (m_resp) begin
            chk("rsp_rdata", rsp_rdata, m_rdata);
            chk("rsp_err", rsp_err, 32'(m_err));
        end
    endtask

    task automatic bus_accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1; req_we = we; req_addr = addr; req_wdata = wdata; rsp_ready = 1;
        step_cycle();
        req_valid = 0;
        chk("rsp_latency", rsp_valid, 1);
    endtask

    task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output logic err);
        bus_accept(we, addr, wdata);
        rdata = rsp_rdata;
        err = rsp_err;
        step_cycle();
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd; logic e;
        bus_access(1'b1, addr, data, rd, e);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd; logic e;
        bus_access(1'b0, addr, 32'd0, rd, e);
        chk(name, rd, exp);
    endtask

    task automatic pulse_step();
        step = 1; step_cycle(); step = 0;
    endtask

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[$];
        logic [31:0] rd;
        logic        e;
        logic [31:0] seq[5];
        int          n;
        logic [31:0] sel;

        rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0;
        rsp_ready = 1; debug_mode = 0; step = 0;
        step_cycle();
        step_cycle();
        rst = 0;
        chk("reset_rdata", rsp_rdata, 0);
        chk("reset_err", rsp_err, 0);
        chk("reset_req_ready", req_ready, 1);

        vecs.push_back('{1'b0, A_CTRL, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_PRE,  32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_CNT,  32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_CMP,  32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_STAT, 32'h0, 32'h0, 1'b0});
        vecs.push_back('{1'b1, A_CMP,  32'h1234_5678, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_CMP,  32'h0, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b1, A_PRE,  32'hABCD_1234, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_PRE,  32'h0, 32'h0000_1234, 1'b0});
        vecs.push_back('{1'b1, A_CTRL, 32'hFFFF_FFF2, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_CTRL, 32'h0, 32'h2, 1'b0});
        vecs.push_back('{1'b1, A_CNT,  32'hCAFE_F00D, 32'h0, 1'b0});
        vecs.push_back('{1'b0, A_CNT,  32'h0, 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{1'b0, BASE + 32'h14, 32'h0, MISS_RD, MISS_ERR});
        vecs.push_back('{1'b0, BASE + 32'h02, 32'h0, MISS_RD, MISS_ERR});
        vecs.push_back('{1'b1, BASE + 32'h2C, 32'h55, MISS_RD, MISS_ERR});
        vecs.push_back('{1'b0, A_CMP,  32'h0, 32'h1234_5678, 1'b0});
        vecs.push_back('{1'b0, 32'hF000_0000, 32'h0, MISS_RD, MISS_ERR});
        vecs.push_back('{1'b1, A_CTRL, 32'h0, 32'h0, 1'b0});
        foreach (vecs[i]) begin
            bus_access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, e);
            chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), e, 32'(vecs[i].exp_err));
        end

        // Prescaled match and irq timing.
        wr(A_PRE, 3); wr(A_CMP, 2); wr(A_CNT, 0);
        bus_accept(1'b1, A_CTRL, 32'h5);
        step_cycle();
        n = 1;
        while (!irq && n < 40) begin step_cycle(); n++; end
        chk("irq_rise_cycle", n, 12);
        rd_chk("status_match", A_STAT, 1);
        bus_accept(1'b1, A_STAT, 32'h1);
        chk("irq_fall", irq, 0);
        step_cycle();
        wr(A_CTRL, 0);

        // Auto-reload sequence under single step.
        debug_mode = 1;
        wr(A_PRE, 0); wr(A_CMP, 1); wr(A_CNT, 0); wr(A_CTRL, 3);
        seq = '{32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
        rd_chk("reload_seq0", A_CNT, seq[0]);
        for (int i = 1; i < 5; i++) begin
            pulse_step();
            rd_chk($sformatf("reload_seq%0d", i), A_CNT, seq[i]);
        end

        // 32-bit wrap without auto-reload.
        wr(A_CTRL, 0); wr(A_CNT, 32'hFFFF_FFFF); wr(A_CMP, 5); wr(A_CTRL, 1);
        pulse_step();
        rd_chk("count_wrap", A_CNT, 0);

        // Debug stepping ignores a large prescale.
        wr(A_CTRL, 0); wr(A_PRE, 100); wr(A_CNT, 0); wr(A_CMP, 1000); wr(A_CTRL, 1);
        for (int i = 0; i < 3; i++) begin pulse_step(); step_cycle(); end
        rd_chk("debug_three_steps", A_CNT, 3);
        for (int i = 0; i < 20; i++) step_cycle();
        rd_chk("debug_no_step_hold", A_CNT, 3);

        // COUNT write wins over a same-cycle tick.
        step = 1; bus_accept(1'b1, A_CNT, 32'h40); step = 0; step_cycle();
        rd_chk("count_write_wins", A_CNT, 32'h40);

        // Match set wins over a same-cycle W1C.
        wr(A_STAT, 1);
        rd_chk("status_cleared", A_STAT, 0);
        wr(A_CNT, 9); wr(A_CMP, 9);
        step = 1; bus_accept(1'b1, A_STAT, 32'h1); step = 0; step_cycle();
        rd_chk("set_beats_w1c", A_STAT, 1);
        wr(A_CTRL, 0);
        debug_mode = 0;

        // Response backpressure.
        wr(A_CMP, 32'hA5A5_0001);
        bus_accept(1'b0, A_CMP, 32'h0);
        req_valid = 1; req_we = 1; req_addr = A_CMP; req_wdata = 32'h77; rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            step_cycle();
            chk("bp_req_ready", req_ready, 0);
            chk("bp_rdata", rsp_rdata, 32'hA5A5_0001);
        end
        req_valid = 0; rsp_ready = 1;
        step_cycle();
        rd_chk("bp_no_accept", A_CMP, 32'hA5A5_0001);

        // Reset during a pending response.
        bus_accept(1'b0, A_CNT, 32'h0);
        rst = 1; step_cycle(); rst = 0;
        chk("rst_drops_rsp", rsp_valid, 0);
        rd_chk("rst_compare", A_CMP, 0);
        rd_chk("rst_status", A_STAT, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            rst = ($urandom_range(0, 399) == 0);
            req_valid = ($urandom_range(0, 2) == 0);
            req_we = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 8) req_addr = BASE + 4 * $urandom_range(0, 4);
            else if (sel == 8) req_addr = BASE + $urandom_range(0, 31);
            else req_addr = $urandom;
            case ($urandom_range(0, 3))
                0: req_wdata = $urandom_range(0, 7);
                1: req_wdata = $urandom_range(0, 3);
                2: req_wdata = 32'hFFFF_FFFC + $urandom_range(0, 3);
                default: req_wdata = $urandom;
            endcase
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 49) == 0) debug_mode = !debug_mode;
            step = ($urandom_range(0, 2) == 0);
            step_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
# mmio_timer

Memory-mapped timer peripheral that sits as a responder on the core's data bus, next to the IO manager. It decodes a word-aligned register window, answers each bus request with a one-entry response handshake, and runs a prescaled 32-bit counter with compare match and an interrupt flag. In debug mode the counter follows the single-step pulse, so timer behaviour stays reproducible while stepping.

## Interface
- BASE_ADDR, 32'hF000_0100, base of the 32-byte register window; must be 32-byte aligned
- PRESCALE_W, 16, width of the prescaler register and its internal counter
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  bus request present
- req_ready  out  1  responder can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_wdata  in  32  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator accepts the response
- rsp_rdata  out  32  read data; 0 for writes
- rsp_err  out  1  decode error; see Configuration
- debug_mode  in  1  1 = counter advances only on step
- step  in  1  single-cycle step pulse
- irq  out  1  STATUS.match & CTRL.irq_en

## Operation
- Registers, given as offsets from BASE_ADDR:
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en. Other bits read 0.
  - 0x04 PRESCALE: low PRESCALE_W bits are R/W.
  - 0x08 COUNT: R/W.
  - 0x0C COMPARE: R/W.
  - 0x10 STATUS: bit0 match. Write 1 to clear.
- Decode hit requires all of: req_addr[31:5]==BASE_ADDR[31:5], offset<=0x10, req_addr[1:0]==0.
- Response FSM, states IDLE and RESP:
  - IDLE: req_ready=1. On req_valid, the request is accepted, register access is performed, rsp_rdata/rsp_err are latched, and the FSM moves to RESP.
  - RESP: req_ready=0 and rsp_valid=1. On rsp_ready, the FSM returns to IDLE.
- Tick generation, when enable=1:
  - debug_mode=0: prescaler counts 0..PRESCALE. tick fires when it equals PRESCALE, and the prescaler then returns to 0. PRESCALE=0 gives a tick every cycle.
  - debug_mode=1: tick = step. The prescaler holds its value.
- On tick:
  - If COUNT==COMPARE: match<=1, and COUNT<=0 if auto_reload, otherwise COUNT+1.
  - Otherwise COUNT<=COUNT+1. Increment is mod 2^32, so 0xFFFF_FFFF wraps to 0.
- Clearing enable freezes COUNT and resets the prescaler to 0.
- Simultaneous events:
  - Software write to COUNT and a tick in the same cycle: the write wins.
  - STATUS W1C and a new match in the same cycle: the set wins.
  - Write to PRESCALE resets the prescaler to 0.
  - A read returns the pre-update value of the register.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, irq=0. All registers and the prescaler are 0. FSM is in IDLE.
- Latency: accepted in cycle N; rsp_valid is high in cycle N+1. Throughput is one request per 2 cycles with rsp_ready tied high.
- rsp_rdata and rsp_err stay stable while rsp_valid=1 and rsp_ready=0.
- irq is registered. It rises 1 cycle after the tick that sets match and falls 1 cycle after the clearing write.
- rst mid-transaction drops rsp_valid the next cycle. The pending response is discarded.

## Configuration
- MMIO_TIMER_ERR_EN defined: a decode miss gives rsp_err=1 and rsp_rdata=32'hDEAD_BEEF. The write is ignored.
- Not defined: rsp_err is tied 0. A miss reads 0, and the write is silently ignored.

## Structure
- mmio_timer_pkg holds:
  - register offset localparams
  - CTRL/STATUS bit index constants
  - the IDLE/RESP state enum
  - the 32'hDEAD_BEEF error constant
- Sub-module mmio_timer_prescaler: inputs enable, debug_mode, step, prescale, clear. Output tick.

## Test plan
- Reset, then read CTRL/PRESCALE/COUNT/COMPARE/STATUS -> all 0. rsp_valid rises exactly 1 cycle after acceptance.
- PRESCALE=3, COMPARE=2, CTRL=0x5 -> match and irq set after the third tick, i.e. 12 cycles after enable plus 1 register cycle. Write STATUS=1 -> irq falls next cycle.
- CTRL=0x3, COMPARE=1 -> COUNT sequence 0,1,0,1. COUNT=0xFFFF_FFFF with auto_reload=0 and COMPARE=5 -> next tick gives COUNT=0.
- debug_mode=1, PRESCALE=100, enable: three step pulses -> COUNT=3. No change without step.
- Hold rsp_ready=0 for 5 cycles after a read -> req_ready stays 0 and rsp_rdata stays stable. A new req_valid is not accepted until the handshake completes.
- Read BASE_ADDR+0x14 and BASE_ADDR+0x02 -> rsp_err=1 and rsp_rdata=0xDEAD_BEEF with the macro defined; rsp_err=0 and rdata=0 without it.
